// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : RAW stall/forwarding control for the 5-stage core plus MD-unit
//            start/busy sequencing.
// Revision : 1.0
// ============================================================================
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_wa,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_wsrc,
  input  logic [1:0] D_md,
  input  logic       D_mduse,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [2:0] fwd_rs_E,
  output logic [2:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M,
  output logic       md_start,
  output logic       md_busy
);

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;
  localparam logic [1:0] WSRC_ALU = 2'd0;
  localparam logic [1:0] WSRC_PC8 = 2'd1;
  localparam logic [1:0] MD_MULT  = 2'd1;

  logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_wa_q, e_wa_d;
  logic [1:0] e_tnew_q, e_tnew_d, e_wsrc_q, e_wsrc_d, e_md_q, e_md_d;
  logic [4:0] m_rt_q, m_rt_d, m_wa_q, m_wa_d;
  logic [1:0] m_tnew_q, m_tnew_d, m_wsrc_q, m_wsrc_d;
  logic [4:0] w_wa_q, w_wa_d;
  logic [1:0] w_wsrc_q, w_wsrc_d;
  logic [3:0] cnt_q, cnt_d;

  function automatic logic hit(input logic [4:0] wa, input logic [4:0] src);
    return (src != 5'd0) && (wa == src);
  endfunction

  function automatic logic raw_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] ewa, input logic [1:0] etn,
                                     input logic [4:0] mwa, input logic [1:0] mtn);
    return (tuse != 2'd3) &&
           ((hit(ewa, src) && (etn > tuse)) || (hit(mwa, src) && (mtn > tuse)));
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] src, input logic [4:0] mwa,
                                       input logic [1:0] mtn, input logic [1:0] mws);
    if (hit(mwa, src) && (mtn == 2'd0)) begin
      if (mws == WSRC_PC8) return 2'd2;
      if (mws == WSRC_ALU) return 2'd1;
    end
    return 2'd0;
  endfunction

  // A pending M result (Tnew > 0) blocks the W path: the operand is fixed up later at M.
  function automatic logic [2:0] sel_e(input logic [4:0] src, input logic [4:0] mwa,
                                       input logic [1:0] mtn, input logic [1:0] mws,
                                       input logic [4:0] wwa, input logic [1:0] wws);
    if (hit(mwa, src)) begin
      if (mtn == 2'd0 && mws == WSRC_PC8) return 3'd3;
      if (mtn == 2'd0 && mws == WSRC_ALU) return 3'd1;
      return 3'd0;
    end
    if (hit(wwa, src)) return (wws == WSRC_PC8) ? 3'd4 : 3'd2;
    return 3'd0;
  endfunction

  always_comb begin
    stall = raw_stall(D_rs, D_Tuse_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q) ||
            raw_stall(D_rt, D_Tuse_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q) ||
            (D_mduse && ((e_md_q != 2'd0) || (cnt_q != 4'd0)));
    fwd_rs_D = sel_d(D_rs, m_wa_q, m_tnew_q, m_wsrc_q);
    fwd_rt_D = sel_d(D_rt, m_wa_q, m_tnew_q, m_wsrc_q);
    fwd_rs_E = sel_e(e_rs_q, m_wa_q, m_tnew_q, m_wsrc_q, w_wa_q, w_wsrc_q);
    fwd_rt_E = sel_e(e_rt_q, m_wa_q, m_tnew_q, m_wsrc_q, w_wa_q, w_wsrc_q);
    fwd_rt_M = 2'd0;
    if (hit(w_wa_q, m_rt_q)) fwd_rt_M = (w_wsrc_q == WSRC_PC8) ? 2'd2 : 2'd1;
    md_start = (e_md_q != 2'd0);
    md_busy  = (cnt_q != 4'd0);
  end

  always_comb begin
    e_rs_d   = stall ? 5'd0 : D_rs;
    e_rt_d   = stall ? 5'd0 : D_rt;
    e_wa_d   = stall ? 5'd0 : D_wa;
    e_tnew_d = stall ? 2'd0 : D_Tnew;
    e_wsrc_d = stall ? 2'd0 : D_wsrc;
    e_md_d   = stall ? 2'd0 : D_md;
    m_rt_d   = e_rt_q;
    m_wa_d   = e_wa_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    m_wsrc_d = e_wsrc_q;
    w_wa_d   = m_wa_q;
    w_wsrc_d = m_wsrc_q;
    // A start in E reloads the countdown even while D is stalled.
    if (e_md_q != 2'd0)      cnt_d = (e_md_q == MD_MULT) ? MULT_CYC : DIV_CYC;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
    else                     cnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_wa_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      e_wsrc_q <= 2'd0;
      e_md_q   <= 2'd0;
      m_rt_q   <= 5'd0;
      m_wa_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      m_wsrc_q <= 2'd0;
      w_wa_q   <= 5'd0;
      w_wsrc_q <= 2'd0;
      cnt_q    <= 4'd0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      e_wsrc_q <= e_wsrc_d;
      e_md_q   <= e_md_d;
      m_rt_q   <= m_rt_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      m_wsrc_q <= m_wsrc_d;
      w_wa_q   <= w_wa_d;
      w_wsrc_q <= w_wsrc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Instruction-level vector table and MD/reset sequences for hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] wa;
    logic [1:0] tnew, wsrc, md;
    logic       mduse;
  } din_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] frsd, frtd;
    logic [2:0] frse, frte;
    logic [1:0] frtm;
    logic       start, busy;
  } dout_t;

  typedef struct packed {
    din_t  d;
    dout_t e;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  din_t  din;
  dout_t dout;
  logic       stall, md_start, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rt_M;
  logic [2:0] fwd_rs_E, fwd_rt_E;

  vec_t  vecs[$];
  dout_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(din.rs), .D_rt(din.rt), .D_Tuse_rs(din.tuse_rs), .D_Tuse_rt(din.tuse_rt),
    .D_wa(din.wa), .D_Tnew(din.tnew), .D_wsrc(din.wsrc), .D_md(din.md), .D_mduse(din.mduse),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .md_start(md_start), .md_busy(md_busy)
  );

  assign dout = '{stall: stall, frsd: fwd_rs_D, frtd: fwd_rt_D, frse: fwd_rs_E,
                  frte: fwd_rt_E, frtm: fwd_rt_M, start: md_start, busy: md_busy};

  // Instruction encodings as seen by the D stage.
  function automatic din_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] urs, input logic [1:0] urt,
                              input logic [4:0] wa, input logic [1:0] tnew,
                              input logic [1:0] wsrc, input logic [1:0] md, input logic mduse);
    return '{rs: rs, rt: rt, tuse_rs: urs, tuse_rt: urt, wa: wa,
             tnew: tnew, wsrc: wsrc, md: md, mduse: mduse};
  endfunction
  function automatic din_t nop();                         return mk(0, 0, 3, 3, 0, 0, 0, 0, 0); endfunction
  function automatic din_t alu(input logic [4:0] wa, rs, rt); return mk(rs, rt, 1, 1, wa, 1, 0, 0, 0); endfunction
  function automatic din_t lw(input logic [4:0] wa, rs);  return mk(rs, 0, 1, 3, wa, 2, 2, 0, 0); endfunction
  function automatic din_t sw(input logic [4:0] rs, rt);  return mk(rs, rt, 1, 2, 0, 0, 0, 0, 0); endfunction
  function automatic din_t beq(input logic [4:0] rs, rt); return mk(rs, rt, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic din_t jal();                         return mk(0, 0, 3, 3, 31, 1, 1, 0, 0); endfunction
  function automatic din_t jr(input logic [4:0] rs);      return mk(rs, 0, 0, 3, 0, 0, 0, 0, 0); endfunction
  function automatic din_t mdop(input logic [1:0] md);    return mk(1, 2, 1, 1, 0, 0, 0, md, 1); endfunction
  function automatic din_t mfxx(input logic [4:0] wa);    return mk(0, 0, 3, 3, wa, 1, 0, 0, 1); endfunction

  function automatic dout_t o(input logic st, input logic [1:0] rsd, rtd, input logic [2:0] rse, rte,
                              input logic [1:0] rtm, input logic sta, bsy);
    return '{stall: st, frsd: rsd, frtd: rtd, frse: rse, frte: rte, frtm: rtm, start: sta, busy: bsy};
  endfunction

  task automatic add(input din_t d, input dout_t e);
    vec_t v;
    v.d = d;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx);
    dout_t exp;
    exp = sb.pop_front();
    n_vec++;
    if (dout !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got stall=%0b fD=%0d/%0d fE=%0d/%0d fM=%0d start=%0b busy=%0b, want stall=%0b fD=%0d/%0d fE=%0d/%0d fM=%0d start=%0b busy=%0b",
               nm, idx, dout.stall, dout.frsd, dout.frtd, dout.frse, dout.frte, dout.frtm, dout.start, dout.busy,
               exp.stall, exp.frsd, exp.frtd, exp.frse, exp.frte, exp.frtm, exp.start, exp.busy);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls, busys, starts;
    logic done;

    reset = 1'b1;
    din   = nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));  // reset state
    add(alu(3, 1, 2),    o(0, 0, 0, 0, 0, 0, 0, 0));
    add(alu(4, 3, 2),    o(0, 0, 0, 0, 0, 0, 0, 0));  // ALU->ALU, no stall
    add(alu(6, 3, 7),    o(0, 1, 0, 1, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 2, 0, 0, 0, 0));
    add(lw(5, 1),        o(0, 0, 0, 0, 0, 0, 0, 0));
    add(beq(5, 0),       o(1, 0, 0, 0, 0, 0, 0, 0));  // load-use Tuse 0: two stalls
    add(beq(5, 0),       o(1, 0, 0, 0, 0, 0, 0, 0));
    add(beq(5, 0),       o(0, 0, 0, 0, 0, 0, 0, 0));
    add(lw(5, 1),        o(0, 0, 0, 0, 0, 0, 0, 0));
    add(sw(1, 5),        o(0, 0, 0, 0, 0, 0, 0, 0));  // store data Tuse 2: no stall
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 1, 0, 0));
    add(jal(),           o(0, 0, 0, 0, 0, 0, 0, 0));
    add(jr(31),          o(1, 0, 0, 0, 0, 0, 0, 0));
    add(jr(31),          o(0, 2, 0, 0, 0, 0, 0, 0));
    add(jal(),           o(0, 0, 0, 4, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));
    add(alu(8, 31, 31),  o(0, 2, 2, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 4, 4, 0, 0, 0));
    add(alu(9, 0, 0),    o(0, 0, 0, 0, 0, 0, 0, 0));
    add(lw(9, 1),        o(0, 0, 0, 0, 0, 0, 0, 0));
    add(sw(1, 9),        o(0, 0, 1, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));  // M pending load blocks W path
    add(nop(),           o(0, 0, 0, 0, 0, 1, 0, 0));
    add(alu(10, 0, 0),   o(0, 0, 0, 0, 0, 0, 0, 0));
    add(alu(10, 0, 0),   o(0, 0, 0, 0, 0, 0, 0, 0));
    add(alu(11, 10, 10), o(0, 1, 1, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 1, 1, 0, 0, 0));  // M beats W on same register
    add(lw(0, 0),        o(0, 0, 0, 0, 0, 1, 0, 0));
    add(beq(0, 0),       o(0, 0, 0, 0, 0, 0, 0, 0));  // $0 never stalls or forwards
    add(sw(0, 0),        o(0, 0, 0, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));
    add(mdop(1),         o(0, 0, 0, 0, 0, 0, 0, 0));
    add(mfxx(12),        o(1, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 5; k++) add(mfxx(12), o(1, 0, 0, 0, 0, 0, 0, 1));
    add(mfxx(12),        o(0, 0, 0, 0, 0, 0, 0, 0));
    add(nop(),           o(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      din = vecs[i].d;
      sb.push_back(vecs[i].e);
      @(negedge clk);
      check("tbl", i);
      next_cycle();
    end

    // div followed by mfhi: the consumer is held until the countdown drains
    din = mdop(2);
    next_cycle();
    din    = mfxx(12);
    stalls = 0;
    busys  = 0;
    starts = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall)    stalls++;
      if (md_busy)  busys++;
      if (md_start) starts++;
      if (!stall) done = 1'b1;
      else        next_cycle();
    end
    cmp_int("div_stall_cycles", stalls, 11);
    cmp_int("div_busy_cycles", busys, 10);
    cmp_int("div_start_cycles", starts, 1);
    next_cycle();

    // reset while busy with a load in E discards everything
    din = mdop(1);
    next_cycle();
    din = lw(5, 1);
    next_cycle();
    din   = beq(5, 0);
    reset = 1'b1;
    sb.push_back(o(1, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    check("pre_reset", 0);
    next_cycle();
    reset = 1'b0;
    sb.push_back(o(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("post_reset", 0);
    next_cycle();
    din = nop();
    sb.push_back(o(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("post_reset", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It tracks the destination register and result timing of every in-flight instruction in E, M and W, and generates the select codes for the D-, E- and M-stage forwarding muxes. It raises the D-stage stall for unresolvable RAW hazards. It also sequences the multiply/divide unit: it issues the start pulse and holds a busy countdown that stalls HI/LO users.

## Interface
- No parameters. Latencies are fixed: MULT_CYC = 5, DIV_CYC = 10.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; all state is cleared on the rising edge of `clk` while high.
- `D_rs`, `D_rt`  in  5 each  source registers of the D-stage instruction.
- `D_Tuse_rs`, `D_Tuse_rt`  in  2 each  cycles until the operand is consumed: 0 = D compare/jr, 1 = E ALU, 2 = M store data, 3 = unused.
- `D_wa`  in  5  destination register; 0 = no write.
- `D_Tnew`  in  2  cycles after entering E until the result is on a forwardable bus: ALU/PC8 = 1, load = 2.
- `D_wsrc`  in  2  result source: 0 = ALU, 1 = PC8, 2 = memory.
- `D_md`  in  2  MD start type: 0 = none, 1 = mult/multu, 2 = div/divu.
- `D_mduse`  in  1  instruction touches the MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- `stall`  out  1  freeze PC and the F/D register, and inject a bubble into E.
- `fwd_rs_D`, `fwd_rt_D`  out  2 each  D mux select: 0 = register file, 1 = ALUOUT_M, 2 = PC8_M.
- `fwd_rs_E`, `fwd_rt_E`  out  3 each  E mux select: 0 = pipeline register, 1 = ALUOUT_M, 2 = mux_Wdata, 3 = PC8_M, 4 = PC8_W.
- `fwd_rt_M`  out  2  M mux select: 0 = pipeline register, 1 = mux_Wdata, 2 = PC8_W.
- `md_start`  out  1  start pulse to the MD unit; high while a start instruction is in E.
- `md_busy`  out  1  MD countdown is non-zero.

## Operation
- Shadow stages are registered: E holds {rs, rt, wa, Tnew, wsrc, md}; M holds {rt, wa, Tnew, wsrc}; W holds {wa, wsrc}.
- Each cycle the shadows advance D→E→M→W.
  - Tnew decrements by 1 per stage and saturates at 0.
  - W Tnew is always 0.
- When `stall` = 1, E loads a bubble (all fields 0). M and W still advance.
- All register matches require a register number ≠ 0. $0 never forwards and never stalls.
- Stall per operand X ∈ {rs, rt} with Tuse ≠ 3:
  - stall if (E_wa == D_X and E_Tnew > Tuse) or (M_wa == D_X and M_Tnew > Tuse).
- MD stall: stall if D_mduse and (E_md ≠ 0 or counter ≠ 0).
- `stall` is the OR of all stall terms.
- D forwarding: if M_wa == D_X and M_Tnew == 0, the select is 1 for ALU and 2 for PC8; otherwise 0. W-stage values reach D through the register-file write-through.
- E forwarding for E_X, nearest stage wins:
  - If M_wa matches: when M_Tnew == 0, select 1 (ALU) or 3 (PC8). When M_Tnew > 0, select 0 and do NOT fall through to W, because the value is picked up later at M.
  - Else if W_wa matches: select 4 if W_wsrc = PC8, otherwise 2.
  - Else select 0.
- M forwarding for M_rt: if W_wa matches, select 2 if PC8, otherwise 1. Else select 0.
- MD countdown (4 bits):
  - On the edge where E_md ≠ 0, load 5 (mult) or 10 (div).
  - Otherwise decrement when non-zero.
- `md_start` = (E_md ≠ 0). `md_busy` = (counter ≠ 0).

## Timing
- All outputs are combinational from the shadow registers and the D inputs; the block adds zero latency.
- State changes only on the rising edge of `clk`.
- Reset: all shadows and the counter are 0. Consequently `stall`, every `fwd_*`, `md_start` and `md_busy` are 0, given D inputs with wa = 0, Tuse = 3, md = 0 and mduse = 0.
- Reset mid-operation: in-flight shadows and the counter are discarded on the next edge.
- Load-use example: a load in E (Tnew 2) with a consumer Tuse 1 stalls 1 cycle. A consumer with Tuse 0 stalls 2 cycles.
- Mult issued at edge t: `md_busy` is high for edges t+1..t+5. A following mfhi leaves D on the first cycle where `md_busy` = 0.
- Simultaneous M and W match on the same register: M wins. A stall and an MD start in E in the same cycle: the counter still loads.

## Test plan
- addu $3 then subu using $3 as rs (Tuse 1) → no stall; next cycle `fwd_rs_E` = 1. One instruction later → `fwd_rs_E` = 2.
- lw $5 then beq on $5 (Tuse 0) → `stall` = 1 for 2 cycles, then `fwd_rs_D` = 0 (register-file write-through). lw $5 then sw with $5 as rt (Tuse 2) → no stall; `fwd_rt_E` = 0, then `fwd_rt_M` = 1.
- jal (wa 31, PC8) then jr $31 → `stall` 1 cycle, then `fwd_rs_D` = 2. jal two instructions ahead of an addu using $31 → `fwd_rs_E` = 4.
- Writes to $0 followed by reads of $0 → all `fwd_*` = 0, `stall` = 0.
- mult followed immediately by mflo → `md_start` 1 cycle, `md_busy` 5 cycles, mflo stalled 6 cycles total. div followed by mfhi → stalled 11 cycles.
- Assert reset while `md_busy` = 1 and a load is in E → next cycle all outputs are 0 and no stall occurs.
